serial_adder_ovf: RTL and testbench

SERIAL_ADDER_OVF -- requirements
Module: serial_adder_ovf

---
 rtl/serial_adder_ovf.sv | 117 +++++++++++
 tb/tb_serial_adder_ovf.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ovf.sv
// Bit-serial adder (LSB first) with per-word overflow flag and a saturating
// count of overflowed words.
//
// Ports:
//   i_clock      rising-edge clock
//   i_reset      synchronous active-high reset
//   i_valid      i_line1/i_line2 carry a valid bit this cycle
//   i_sync       restart word alignment; current bit (if valid) is bit 0
//   i_line1      serial operand A, LSB first
//   i_line2      serial operand B, LSB first
//   i_clr_count  clear the overflow counter
//   o_outp       registered serial sum bit
//   o_ovalid     o_outp holds a newly produced sum bit
//   o_olast      o_outp is the MSB of a word
//   o_overflw    word just completed overflowed (only with o_olast)
//   o_ovf_count  saturating count of overflowed words
module serial_adder_ovf #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic             i_sync,
  input  logic             i_line1,
  input  logic             i_line2,
  input  logic             i_clr_count,
  output logic             o_outp,
  output logic             o_ovalid,
  output logic             o_olast,
  output logic             o_overflw,
  output logic [CNT_W-1:0] o_ovf_count
);

  localparam int unsigned     IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [IDX_W-1:0] r_idx;
  logic             r_cy;
  logic             r_outp;
  logic             r_ovalid;
  logic             r_olast;
  logic             r_overflw;
  logic [CNT_W-1:0] r_cnt;

  logic [IDX_W-1:0] w_idx_eff;
  logic             w_cin;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_ovf;
  logic             w_ovf_evt;

  // Full-adder slice; sync forces the current bit to be bit 0 of a fresh word.
  always_comb begin
    w_idx_eff = i_sync ? '0 : r_idx;
    w_cin     = (w_idx_eff == '0) ? 1'b0 : r_cy;
    w_sum     = i_line1 ^ i_line2 ^ w_cin;
    w_cout    = (i_line1 & i_line2) | (i_line1 & w_cin) | (i_line2 & w_cin);
    w_last    = (w_idx_eff == LAST_IDX);
    // Signed overflow: carry into the MSB differs from carry out of it.
    w_ovf     = (SIGNED != 0) ? (w_cin ^ w_cout) : w_cout;
    w_ovf_evt = i_valid & w_last & w_ovf;
  end

  // Bit index, carry and serial output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_idx     <= '0;
      r_cy      <= 1'b0;
      r_outp    <= 1'b0;
      r_ovalid  <= 1'b0;
      r_olast   <= 1'b0;
      r_overflw <= 1'b0;
    end else begin
      r_ovalid  <= 1'b0;
      r_olast   <= 1'b0;
      r_overflw <= 1'b0;
      if (i_valid) begin
        r_outp   <= w_sum;
        r_ovalid <= 1'b1;
        if (w_last) begin
          r_idx     <= '0;
          r_cy      <= 1'b0;
          r_olast   <= 1'b1;
          r_overflw <= w_ovf;
        end else begin
          r_idx <= w_idx_eff + IDX_W'(1);
          r_cy  <= w_cout;
        end
      end else if (i_sync) begin
        r_idx <= '0;
        r_cy  <= 1'b0;
      end
    end
  end

  // Saturating overflow counter; clear wins over a same-edge event.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr_count) begin
      r_cnt <= '0;
    end else if (w_ovf_evt && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_outp      = r_outp;
  assign o_ovalid    = r_ovalid;
  assign o_olast     = r_olast;
  assign o_overflw   = r_overflw;
  assign o_ovf_count = r_cnt;

endmodule

// File: tb/tb_serial_adder_ovf.sv
// Bench for serial_adder_ovf: an unsigned (CNT_W=2) and a signed (CNT_W=8)
// instance share one directed stimulus stream and are checked every cycle
// against an arithmetic word-level model, plus literal expectations.
module tb_serial_adder_ovf;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid, sync, l1, l2, clr;
  logic       outp0, ovalid0, olast0, ovf0;
  logic [1:0] cnt0;
  logic       outp1, ovalid1, olast1, ovf1;
  logic [7:0] cnt1;

  serial_adder_ovf #(.WIDTH(W), .SIGNED(0), .CNT_W(2)) u_dut_u (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_sync(sync),
    .i_line1(l1), .i_line2(l2), .i_clr_count(clr),
    .o_outp(outp0), .o_ovalid(ovalid0), .o_olast(olast0),
    .o_overflw(ovf0), .o_ovf_count(cnt0));

  serial_adder_ovf #(.WIDTH(W), .SIGNED(1), .CNT_W(8)) u_dut_s (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_sync(sync),
    .i_line1(l1), .i_line2(l2), .i_clr_count(clr),
    .o_outp(outp1), .o_ovalid(ovalid1), .o_olast(olast1),
    .o_overflw(ovf1), .o_ovf_count(cnt1));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Word-level model: accumulate operands as integers, read sum bits from
  // their arithmetic sum, decide overflow from the numeric range.
  int   m_k, m_a, m_b, m_s, m_sa;
  logic e_outp, e_ovalid, e_olast, e_ovf0, e_ovf1;
  int   e_cnt0, e_cnt1;

  always @(posedge clk) begin
    if (rst) begin
      m_k = 0; m_a = 0; m_b = 0;
      e_outp = 0; e_ovalid = 0; e_olast = 0; e_ovf0 = 0; e_ovf1 = 0;
      e_cnt0 = 0; e_cnt1 = 0;
    end else begin
      e_ovalid = 0; e_olast = 0; e_ovf0 = 0; e_ovf1 = 0;
      if (sync) begin m_k = 0; m_a = 0; m_b = 0; end
      if (valid) begin
        m_a = m_a + (int'(l1) << m_k);
        m_b = m_b + (int'(l2) << m_k);
        m_s = m_a + m_b;
        e_outp = m_s[m_k];
        e_ovalid = 1;
        if (m_k == W - 1) begin
          e_olast = 1;
          e_ovf0 = (m_s >= (1 << W));
          m_sa = ((m_a >= (1 << (W-1))) ? m_a - (1 << W) : m_a)
               + ((m_b >= (1 << (W-1))) ? m_b - (1 << W) : m_b);
          e_ovf1 = (m_sa > (1 << (W-1)) - 1) || (m_sa < -(1 << (W-1)));
          m_k = 0; m_a = 0; m_b = 0;
        end else begin
          m_k++;
        end
      end
      if (clr) begin
        e_cnt0 = 0; e_cnt1 = 0;
      end else begin
        if (e_ovf0 && e_cnt0 < 3)   e_cnt0++;
        if (e_ovf1 && e_cnt1 < 255) e_cnt1++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("outp_u",   outp0,   e_outp);
      chk("ovalid_u", ovalid0, e_ovalid);
      chk("olast_u",  olast0,  e_olast);
      chk("ovf_u",    ovf0,    e_ovf0);
      chk("cnt_u",    cnt0,    e_cnt0);
      chk("outp_s",   outp1,   e_outp);
      chk("ovalid_s", ovalid1, e_ovalid);
      chk("olast_s",  olast1,  e_olast);
      chk("ovf_s",    ovf1,    e_ovf1);
      chk("cnt_s",    cnt1,    e_cnt1);
      chk("ovf_wo_olast_u", ovf0 & ~olast0, 0);
      chk("ovf_wo_olast_s", ovf1 & ~olast1, 0);
    end
  end

  task automatic step(input logic v, input logic s, input logic a, input logic b,
                      input logic c, input logic r);
    valid = v; sync = s; l1 = a; l2 = b; clr = c; rst = r;
    @(negedge clk);
  endtask

  task automatic word(input int a, input int b, output logic [3:0] ob);
    for (int i = 0; i < W; i++) begin
      step(1, 0, a[i], b[i], 0, 0);
      ob[i] = outp0;
    end
  endtask

  logic [3:0] ob;
  int pa [4] = '{3, 7, 12, 8};
  int pb [4] = '{4, 9, 5, 8};

  initial begin
    valid = 0; sync = 0; l1 = 0; l2 = 0; clr = 0; rst = 1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_ovalid", ovalid0, 0);
    chk("rst_cnt", cnt0, 0);

    // 9 + 8: unsigned and signed overflow
    word(9, 8, ob);
    chk("9p8_bits", ob, 4'b0001);
    chk("9p8_olast", olast0, 1);
    chk("9p8_ovf_u", ovf0, 1);
    chk("9p8_cnt_u", cnt0, 1);

    // 5 + 3: signed overflow only
    word(5, 3, ob);
    chk("5p3_bits", ob, 4'b1000);
    chk("5p3_ovf_s", ovf1, 1);
    chk("5p3_ovf_u", ovf0, 0);

    // -1 + -1: unsigned overflow only
    word(15, 15, ob);
    chk("m1m1_bits", ob, 4'b1110);
    chk("m1m1_ovf_s", ovf1, 0);
    chk("m1m1_ovf_u", ovf0, 1);

    // 9 + 8 with a three-cycle stall after bit 1
    step(1, 0, 1, 0, 0, 0); ob[0] = outp0;
    step(1, 0, 0, 0, 0, 0); ob[1] = outp0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0, 0);
      chk("stall_ovalid", ovalid0, 0);
    end
    step(1, 0, 0, 0, 0, 0); ob[2] = outp0;
    chk("stall_no_olast", olast0, 0);
    step(1, 0, 1, 1, 0, 0); ob[3] = outp0;
    chk("stall_bits", ob, 4'b0001);
    chk("stall_ovf_u", ovf0, 1);
    chk("stall_cnt_u", cnt0, 3);

    // Two bits of 1+1, then SYNC restarts with a 0+0 word
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("sync_no_olast", olast0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("sync_no_olast3", olast0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("sync_olast", olast0, 1);
    chk("sync_ovf", ovf0, 0);

    // Saturation at 3, then clear on an overflow edge
    word(9, 8, ob);
    chk("sat_cnt_a", cnt0, 3);
    word(9, 8, ob);
    chk("sat_cnt_b", cnt0, 3);
    for (int i = 0; i < W; i++) step(1, 0, (i == 0) || (i == 3), i == 3, i == 3, 0);
    chk("clr_ovf", ovf0, 1);
    chk("clr_cnt_u", cnt0, 0);
    chk("clr_cnt_s", cnt1, 0);

    // Back-to-back words with no gap cycles
    for (int w = 0; w < 4; w++) word(pa[w], pb[w], ob);
    chk("b2b_cnt_u", cnt0, 3);

    // Mid-word reset, then a fresh word starts at bit 0
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1);
    chk("rst_mid_outp", outp0, 0);
    chk("rst_mid_ovalid", ovalid0, 0);
    chk("rst_mid_olast", olast0, 0);
    chk("rst_mid_cnt", cnt0, 0);
    word(9, 8, ob);
    chk("post_rst_bits", ob, 4'b0001);
    chk("post_rst_ovf", ovf0, 1);
    chk("post_rst_cnt", cnt0, 1);

    step(0, 0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
